contador_regressivo_bcd: RTL and testbench

- Two-digit BCD countdown timer that consumes the tens/units preset produced by the traffic-light preset generator.
- Loads the preset on a load strobe and decrements once per prescaled tick.
- Raises a one-cycle `fim` pulse when the count reaches 00; the controller uses that pulse to advance `estado`.
- Drives both digits onto active-low seven-segment outputs for the board display.

---
 rtl/contador_regressivo_bcd.sv | 110 +++++++++++
 tb/tb_contador_regressivo_bcd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_regressivo_bcd.sv
// Two-digit BCD countdown timer with prescaled tick, terminal-count pulse and
// active-low seven-segment drivers for both digits.
module contador_regressivo_bcd #(
   parameter int TICK_DIV = 50000000,
   parameter int PRE_W    = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       carrega,
   input  logic       habilita,
   input  logic [3:0] unid_preset,
   input  logic [1:0] dez_preset,
   output logic [3:0] unid,
   output logic [1:0] dez,
   output logic       ativo,
   output logic       fim,
   output logic [6:0] seg_unid,
   output logic [6:0] seg_dez
);

   typedef enum logic {OCIOSO = 1'b0, CONTANDO = 1'b1} estado_t;

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   estado_t          estado, estado_nxt;
   logic [3:0]       unid_nxt;
   logic [1:0]       dez_nxt;
   logic [PRE_W-1:0] pre, pre_nxt;
   logic             fim_nxt;
   logic [3:0]       unid_carga;

   function automatic logic [3:0] sat_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign unid_carga = sat_bcd(unid_preset);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= OCIOSO;
         unid   <= 4'd0;
         dez    <= 2'd0;
         pre    <= '0;
         fim    <= 1'b0;
      end else begin
         estado <= estado_nxt;
         unid   <= unid_nxt;
         dez    <= dez_nxt;
         pre    <= pre_nxt;
         fim    <= fim_nxt;
      end
   end

   // Load wins over a tick in the same cycle; it also restarts the period.
   always_comb begin
      estado_nxt = estado;
      unid_nxt   = unid;
      dez_nxt    = dez;
      pre_nxt    = pre;
      fim_nxt    = 1'b0;
      if (carrega) begin
         unid_nxt = unid_carga;
         dez_nxt  = dez_preset;
         pre_nxt  = '0;
         if ((unid_carga == 4'd0) && (dez_preset == 2'd0)) begin
            estado_nxt = OCIOSO;
            fim_nxt    = 1'b1;
         end else begin
            estado_nxt = CONTANDO;
         end
      end else if ((estado == CONTANDO) && habilita) begin
         if (pre == PRE_MAX) begin
            pre_nxt = '0;
            if (unid != 4'd0) begin
               unid_nxt = unid - 4'd1;
            end else if (dez != 2'd0) begin
               unid_nxt = 4'd9;
               dez_nxt  = dez - 2'd1;
            end
            if ((unid == 4'd1) && (dez == 2'd0)) begin
               estado_nxt = OCIOSO;
               fim_nxt    = 1'b1;
            end
         end else begin
            pre_nxt = pre + 1'b1;
         end
      end
   end

   assign ativo    = (estado == CONTANDO);
   assign seg_unid = seg7(unid);
   assign seg_dez  = seg7({2'b00, dez});

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// Bench for contador_regressivo_bcd: directed scenarios plus random traffic,
// compared every cycle against an integer-valued countdown model.
module tb_contador_regressivo_bcd;

   localparam int TICK_DIV = 4;
   localparam int PRE_W    = 3;

   logic       clk;
   logic       rst_n;
   logic       carrega;
   logic       habilita;
   logic [3:0] unid_preset;
   logic [1:0] dez_preset;
   logic [3:0] unid;
   logic [1:0] dez;
   logic       ativo;
   logic       fim;
   logic [6:0] seg_unid;
   logic [6:0] seg_dez;

   int n_cmp;
   int n_bad;

   // Reference: count held as a plain integer 0..39 plus elapsed cycles in the period.
   int m_val;
   int m_phase;
   bit m_ativo;
   bit m_fim;

   logic [6:0] seg_tab [10];

   contador_regressivo_bcd #(
      .TICK_DIV(TICK_DIV),
      .PRE_W   (PRE_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .carrega    (carrega),
      .habilita   (habilita),
      .unid_preset(unid_preset),
      .dez_preset (dez_preset),
      .unid       (unid),
      .dez        (dez),
      .ativo      (ativo),
      .fim        (fim),
      .seg_unid   (seg_unid),
      .seg_dez    (seg_dez)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_val   = 0;
      m_phase = 0;
      m_ativo = 0;
      m_fim   = 0;
   endtask

   task automatic model_edge();
      int v;
      m_fim = 0;
      if (!rst_n) begin
         model_reset();
      end else if (carrega) begin
         v       = ((unid_preset > 9) ? 9 : int'(unid_preset)) + 10 * int'(dez_preset);
         m_val   = v;
         m_phase = 0;
         if (v == 0) begin
            m_ativo = 0;
            m_fim   = 1;
         end else begin
            m_ativo = 1;
         end
      end else if (m_ativo && habilita) begin
         m_phase++;
         if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_val--;
            if (m_val == 0) begin
               m_ativo = 0;
               m_fim   = 1;
            end
         end
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, ".cnt"}, {24'd0, unid, dez, ativo, fim},
          {24'd0, 4'(m_val % 10), 2'(m_val / 10), m_ativo, m_fim});
      chk({tag, ".seg"}, {18'd0, seg_unid, seg_dez},
          {18'd0, seg_tab[m_val % 10], seg_tab[m_val / 10]});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare(tag);
   endtask

   task automatic load(input string tag, input logic [1:0] d, input logic [3:0] u);
      carrega     = 1'b1;
      dez_preset  = d;
      unid_preset = u;
      step(tag);
      carrega     = 1'b0;
   endtask

   initial begin
      int cyc;
      bit seen;
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      n_cmp       = 0;
      n_bad       = 0;
      rst_n       = 1'b0;
      carrega     = 1'b0;
      habilita    = 1'b1;
      unid_preset = 4'd0;
      dez_preset  = 2'd0;
      model_reset();
      #1;
      compare("reset");
      step("reset");
      step("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("idle");

      // 12 down to 00
      load("t1", 2'd1, 4'd2);
      for (int i = 0; i < 12 * TICK_DIV + 3; i++) step("t1");

      // zero preset
      load("t2", 2'd0, 4'd0);
      chk("t2.fim", {31'd0, fim}, 32'd1);
      step("t2");
      chk("t2.fim_drop", {31'd0, fim}, 32'd0);

      // reload with prescaler at its last count
      load("t3", 2'd0, 4'd5);
      for (int i = 0; i < 11; i++) step("t3");
      load("t3", 2'd3, 4'd0);
      chk("t3.load30", {28'd0, dez, unid}, {28'd0, 2'd3, 4'd0});
      for (int i = 0; i < 3; i++) step("t3");
      chk("t3.hold30", {28'd0, dez, unid}, {28'd0, 2'd3, 4'd0});
      step("t3");
      chk("t3.to29", {28'd0, dez, unid}, {28'd0, 2'd2, 4'd9});

      // freeze mid-period
      load("t4", 2'd1, 4'd0);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         habilita = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'b1;
         step("t4");
         cyc++;
         if (fim) seen = 1;
      end
      habilita = 1'b1;
      chk("t4.cycles", 32'(cyc), 32'(10 * TICK_DIV + 10));

      // units clamp
      load("t5", 2'd0, 4'hC);
      chk("t5.clamp", {28'd0, dez, unid}, {28'd0, 2'd0, 4'd9});
      for (int i = 0; i < 9 * TICK_DIV + 2; i++) step("t5");

      // asynchronous reset mid-count
      load("t6", 2'd0, 4'd9);
      for (int i = 0; i < 2 * TICK_DIV; i++) step("t6");
      chk("t6.at07", {28'd0, dez, unid}, {28'd0, 2'd0, 4'd7});
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare("t6.async");
      step("t6.inrst");
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4 * TICK_DIV; i++) begin
         step("t6.after");
         chk("t6.nofim", {31'd0, fim}, 32'd0);
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         carrega     = ($urandom_range(0, 15) == 0);
         habilita    = ($urandom_range(0, 3) != 0);
         dez_preset  = 2'($urandom_range(0, 3));
         unid_preset = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) dez_preset = 2'd0;
         step("rand");
      end
      carrega = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
